// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned MUL_LAT_DEF = 3;
    localparam int unsigned DIV_LAT_DEF = 33;

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } mdu_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctl_t;

    typedef struct packed {
        stage_ctl_t f;
        stage_ctl_t d;
        stage_ctl_t e;
        stage_ctl_t m;
        stage_ctl_t w;
    } hazard_out_t;

    // Load in E writes a register the instruction in D reads (x0 never counts).
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// MUL/DIV occupancy timer: tracks how long a multi-cycle op keeps E busy.
module hazard_ctrl_mdu_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic hold,
    output logic busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div ? DIV_LOAD : MUL_LOAD;

    // State and counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, counter update and busy indication.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy    = 1'b0;
        case (state)
            RUN: begin
                busy = start && (load_val != '0);
                // An op held in E by a data-memory stall has not really issued yet.
                if (start && !hold) begin
                    cnt_n = load_val;
                    if (load_val != '0) begin
                        state_n = MDU;
                    end
                end
            end
            MDU: begin
                busy = 1'b1;
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end
                if (cnt == CNT_ONE) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline controller: per-stage stall/flush from hazards and wait states.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rd_E,
    input  logic       memread_E,
    input  logic       branch_taken_E,
    input  logic       mdu_start_E,
    input  logic       mdu_is_div_E,
    input  logic       ibus_wait,
    input  logic       dbus_wait,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       stall_W,
    output logic       reset_D,
    output logic       reset_E,
    output logic       reset_M,
    output logic       reset_W,
    output logic       mdu_busy
);

    hazard_out_t hz;
    logic        kill_pending;
    logic        redirect;
    logic        load_use;

    hazard_ctrl_mdu_timer #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) u_mdu_timer (
        .clk   (clk),
        .reset (reset),
        .start (mdu_start_E),
        .is_div(mdu_is_div_E),
        .hold  (dbus_wait),
        .busy  (mdu_busy)
    );

    assign load_use = load_use_hit(memread_E, rd_E, rs1_D, rs2_D);
    // A redirect only takes effect when E is free to move on.
    assign redirect = branch_taken_E && !dbus_wait && !mdu_busy;

    // Wrong-path fetch tracking across instruction-bus wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_pending <= 1'b0;
        end else if (redirect && (ibus_wait || kill_pending)) begin
            kill_pending <= 1'b1;
        end else if (!ibus_wait) begin
            kill_pending <= 1'b0;
        end
    end

    // Priority stall/flush pattern, oldest source first.
    always_comb begin
        hz = '0;
        if (dbus_wait) begin
            hz.f.stall = 1'b1;
            hz.d.stall = 1'b1;
            hz.e.stall = 1'b1;
            hz.m.stall = 1'b1;
            hz.w.flush = 1'b1;
        end else if (mdu_busy) begin
            hz.f.stall = 1'b1;
            hz.d.stall = 1'b1;
            hz.e.stall = 1'b1;
            hz.m.flush = 1'b1;
        end else if (redirect) begin
            // Redirect overrides load-use and fetch stalls: D is wrong-path, PC takes the target.
            hz.d.flush = 1'b1;
            hz.e.flush = 1'b1;
        end else if (load_use) begin
            hz.f.stall = 1'b1;
            hz.d.stall = 1'b1;
            hz.e.flush = 1'b1;
        end else if (ibus_wait || kill_pending) begin
            hz.f.stall = 1'b1;
            hz.d.flush = 1'b1;
        end
    end

    assign stall_F = hz.f.stall;
    assign stall_D = hz.d.stall;
    assign stall_E = hz.e.stall;
    assign stall_M = hz.m.stall;
    assign stall_W = hz.w.stall;
    assign reset_D = hz.d.flush;
    assign reset_E = hz.e.flush;
    assign reset_M = hz.m.flush;
    assign reset_W = hz.w.flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic.
module tb_hazard_ctrl;

    localparam int MUL_L = 3;
    localparam int DIV_L = 33;

    typedef struct {
        logic       reset;
        logic [4:0] rs1, rs2, rd;
        logic       memread, branch, start, is_div, ibus, dbus;
    } in_t;

    typedef struct {
        logic [9:0] exp;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    in_t  cur, nx;
    logic stall_F, stall_D, stall_E, stall_M, stall_W;
    logic reset_D, reset_E, reset_M, reset_W, mdu_busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: remaining occupancy cycles after the current one, and kill flag.
    int   rem  = 0;
    bit   kill = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MUL_LAT(MUL_L),
        .DIV_LAT(DIV_L)
    ) dut (
        .clk           (clk),
        .reset         (cur.reset),
        .rs1_D         (cur.rs1),
        .rs2_D         (cur.rs2),
        .rd_E          (cur.rd),
        .memread_E     (cur.memread),
        .branch_taken_E(cur.branch),
        .mdu_start_E   (cur.start),
        .mdu_is_div_E  (cur.is_div),
        .ibus_wait     (cur.ibus),
        .dbus_wait     (cur.dbus),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .stall_E       (stall_E),
        .stall_M       (stall_M),
        .stall_W       (stall_W),
        .reset_D       (reset_D),
        .reset_E       (reset_E),
        .reset_M       (reset_M),
        .reset_W       (reset_W),
        .mdu_busy      (mdu_busy)
    );

    function automatic bit model_busy(input in_t i);
        int lat = i.is_div ? DIV_L : MUL_L;
        return (rem > 0) || (i.start && lat > 1);
    endfunction

    // Expected {stall F,D,E,M,W, reset D,E,M,W, busy} for the current inputs and model state.
    function automatic logic [9:0] model_out(input in_t i);
        bit sf = 0, sd = 0, se = 0, sm = 0, rd_ = 0, re = 0, rm = 0, rw = 0;
        bit busy = model_busy(i);
        bit lu   = i.memread && i.rd != 0 && (i.rd == i.rs1 || i.rd == i.rs2);
        if (i.dbus) begin
            sf = 1; sd = 1; se = 1; sm = 1; rw = 1;
        end else if (busy) begin
            sf = 1; sd = 1; se = 1; rm = 1;
        end else if (i.branch) begin
            rd_ = 1; re = 1;
        end else if (lu) begin
            sf = 1; sd = 1; re = 1;
        end else if (i.ibus || kill) begin
            sf = 1; rd_ = 1;
        end
        return {sf, sd, se, sm, 1'b0, rd_, re, rm, rw, busy};
    endfunction

    // Clock-edge update of the model using the inputs held over the edge.
    task automatic model_edge(input in_t i);
        bit busy, redirect;
        int lat;
        if (i.reset) begin
            rem = 0; kill = 0;
            return;
        end
        busy     = model_busy(i);
        redirect = i.branch && !i.dbus && !busy;
        lat      = i.is_div ? DIV_L : MUL_L;
        if (rem > 0)                     rem = rem - 1;
        else if (i.start && !i.dbus)     rem = lat - 1;
        if (redirect && (i.ibus || kill)) kill = 1;
        else if (!i.ibus)                 kill = 0;
    endtask

    task automatic idle_nx();
        nx = '{reset: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, memread: 1'b0,
               branch: 1'b0, start: 1'b0, is_div: 1'b0, ibus: 1'b0, dbus: 1'b0};
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        model_edge(cur);
        #1;
        cur = nx;
        if (cur.reset) begin
            rem = 0; kill = 0;
        end
        e.exp = model_out(cur);
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = q.pop_front();
            got = {stall_F, stall_D, stall_E, stall_M, stall_W,
                   reset_D, reset_E, reset_M, reset_W, mdu_busy};
            n_checks++;
            if (got === e.exp) n_pass++;
            else $display("FAIL %s: got %b expected %b (sF sD sE sM sW rD rE rM rW busy)",
                          e.tag, got, e.exp);
        end
    end

    initial begin
        idle_nx();
        cur = nx;
        cur.reset = 1'b1;
        nx.reset  = 1'b1;
        steps(2, "reset");
        idle_nx();
        steps(2, "post_reset");

        // Load-use on rs1, then bubble clears; x0 never hazards.
        nx.memread = 1; nx.rd = 5'd5; nx.rs1 = 5'd5; step("load_use");
        idle_nx(); step("load_use_release");
        nx.memread = 1; nx.rd = 5'd0; nx.rs1 = 5'd0; step("load_x0");
        idle_nx(); nx.memread = 1; nx.rd = 5'd7; nx.rs2 = 5'd7; step("load_use_rs2");
        idle_nx(); step("idle");

        // DIV and MUL occupancy.
        nx.start = 1; nx.is_div = 1; step("div_issue");
        idle_nx(); steps(DIV_L + 2, "div_busy");
        nx.start = 1; nx.is_div = 0; step("mul_issue");
        idle_nx(); steps(MUL_L + 2, "mul_busy");

        // Data-bus wait in the middle of a divide.
        nx.start = 1; nx.is_div = 1; step("div2_issue");
        idle_nx(); steps(5, "div2_busy");
        nx.dbus = 1; steps(4, "div2_dbus");
        idle_nx(); steps(DIV_L, "div2_tail");

        // Redirect with the fetch still outstanding.
        nx.branch = 1; nx.ibus = 1; step("redirect_ibus");
        idle_nx(); nx.ibus = 1; steps(3, "kill_wait");
        idle_nx(); steps(3, "kill_release");

        // Redirect cancels load-use.
        nx.branch = 1; nx.memread = 1; nx.rd = 5'd9; nx.rs1 = 5'd9; step("redirect_lu");
        idle_nx(); step("idle");

        // Reset in the middle of a divide.
        nx.start = 1; nx.is_div = 1; step("div3_issue");
        idle_nx(); steps(9, "div3_busy");
        nx.reset = 1; step("reset_mid_div");
        idle_nx(); steps(3, "after_reset");

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            nx.reset   = ($urandom_range(0, 199) == 0);
            nx.rs1     = 5'($urandom_range(0, 3));
            nx.rs2     = 5'($urandom_range(0, 3));
            nx.rd      = 5'($urandom_range(0, 3));
            nx.memread = ($urandom_range(0, 9) < 3);
            nx.branch  = ($urandom_range(0, 9) < 2);
            nx.start   = ($urandom_range(0, 19) == 0);
            nx.is_div  = ($urandom_range(0, 3) == 0);
            nx.ibus    = ($urandom_range(0, 9) < 3);
            nx.dbus    = ($urandom_range(0, 9) < 1);
            step("random");
        end
        idle_nx();
        steps(2, "drain");

        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
